alu_datapath_ctrl: RTL



---
 rtl/alu_ctrl_pkg.sv | 32 +++
 rtl/alu_ctrl_decode.sv | 26 ++
 rtl/alu_datapath_ctrl.sv | 114 +++++++++++
 3 files changed

// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: shared types and constants for the ALU datapath controller
// Contents:
//   state_t  - controller FSM states (IDLE, DECODE, EXEC, WB)
//   OP_*     - opcodes with special decode handling
//   *_HI/_LO - instruction field positions
//   dec_t    - decoded instruction {sel_a, sel_b, dest, op, imm, is_imm, wb}
package alu_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_t;
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_CMP  = 4'hB;
  localparam logic [3:0] OP_MOVI = 4'hD;
  localparam int OP_HI = 15;
  localparam int OP_LO = 12;
  localparam int RD_HI = 11;
  localparam int RD_LO = 8;
  localparam int RA_HI = 7;
  localparam int RA_LO = 4;
  localparam int RB_HI = 3;
  localparam int RB_LO = 0;
  localparam int SEL_W = 4;
  localparam int OPF_W = 4;
  localparam int DATA_W = 16;
  typedef struct packed {
    logic [SEL_W-1:0]  sel_a;
    logic [SEL_W-1:0]  sel_b;
    logic [SEL_W-1:0]  dest;
    logic [OPF_W-1:0]  op;
    logic [DATA_W-1:0] imm;
    logic              is_imm;
    logic              wb;
  } dec_t;
endpackage

// File: rtl/alu_ctrl_decode.sv
// alu_ctrl_decode: combinational instruction decoder for the ALU controller
// Ports:
//   instr - 16-bit instruction word {op, rdest, rsrc_a, rsrc_b} / imm in low byte
//   dec   - decoded fields; imm is sign-extended only for MOVI, zero otherwise
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
#(
  parameter int IMM_W = 8
) (
  input  logic [15:0] instr,
  output dec_t        dec
);
  logic [OPF_W-1:0] op;
  logic             movi;
  assign op   = instr[OP_HI:OP_LO];
  assign movi = op == OP_MOVI;
  always_comb begin
    dec.sel_a  = instr[RA_HI:RA_LO];
    dec.sel_b  = movi ? '0 : instr[RB_HI:RB_LO];
    dec.dest   = instr[RD_HI:RD_LO];
    dec.op     = op;
    dec.imm    = movi ? DATA_W'(signed'(instr[IMM_W-1:0])) : '0;
    dec.is_imm = movi;
    dec.wb     = op != OP_NOP && op != OP_CMP;
  end
endmodule

// File: rtl/alu_datapath_ctrl.sv
// alu_datapath_ctrl: 4-cycle control FSM driving the register-bank/mux/ALU datapath
// Ports:
//   clk, reset          - clock; asynchronous active-low reset
//   instr, instr_valid  - instruction handshake input, accepted when instr_ready
//   instr_ready         - high only in IDLE
//   mux_sel_a/b         - operand mux selects (valid in EXEC and WB)
//   imm_sel, imm_out    - immediate operand select and sign-extended immediate
//   alu_opcode          - opcode presented to the ALU
//   reg_enable          - one-hot bank write enable, asserted only in WB
//   done                - one-cycle retire pulse in WB
//   retired_cnt, wb_cnt - retire / register-write counters (ALU_CTRL_PERF_CNT_EN only)
// Build option: define ALU_CTRL_PERF_CNT_EN to add the performance counters.
module alu_datapath_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter  int NUM_REGS = 16,
  parameter  int OP_W     = 4,
  parameter  int IMM_W    = 8,
  localparam int SW       = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [15:0]         instr,
  input  logic                instr_valid,
  output logic                instr_ready,
  output logic [SW-1:0]       mux_sel_a,
  output logic [SW-1:0]       mux_sel_b,
  output logic                imm_sel,
  output logic [15:0]         imm_out,
  output logic [OP_W-1:0]     alu_opcode,
  output logic [NUM_REGS-1:0] reg_enable,
  output logic                done
`ifdef ALU_CTRL_PERF_CNT_EN
  ,
  output logic [15:0]         retired_cnt,
  output logic [15:0]         wb_cnt
`endif
);
  state_t        state;
  logic [15:0]   ir;
  dec_t          dec;
  logic [SW-1:0] dest_q;
  logic          wb_q;
  alu_ctrl_decode #(.IMM_W(IMM_W)) u_dec (
    .instr(ir),
    .dec  (dec)
  );
  // Datapath outputs are loaded straight from the decoder at the DECODE exit
  // edge so they are visible throughout EXEC and held through WB.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state       <= IDLE;
      ir          <= '0;
      dest_q      <= '0;
      wb_q        <= 1'b0;
      instr_ready <= 1'b0;
      mux_sel_a   <= '0;
      mux_sel_b   <= '0;
      imm_sel     <= 1'b0;
      imm_out     <= '0;
      alu_opcode  <= '0;
      reg_enable  <= '0;
      done        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (instr_ready && instr_valid) begin
            ir          <= instr;
            instr_ready <= 1'b0;
            state       <= DECODE;
          end else begin
            instr_ready <= 1'b1;
          end
        end
        DECODE: begin
          dest_q     <= SW'(dec.dest);
          wb_q       <= dec.wb;
          mux_sel_a  <= SW'(dec.sel_a);
          mux_sel_b  <= SW'(dec.sel_b);
          alu_opcode <= OP_W'(dec.op);
          imm_sel    <= dec.is_imm;
          imm_out    <= dec.imm;
          state      <= EXEC;
        end
        EXEC: begin
          reg_enable <= wb_q ? NUM_REGS'(1) << dest_q : '0;
          done       <= 1'b1;
          state      <= WB;
        end
        WB: begin
          reg_enable  <= '0;
          done        <= 1'b0;
          mux_sel_a   <= '0;
          mux_sel_b   <= '0;
          alu_opcode  <= '0;
          imm_sel     <= 1'b0;
          imm_out     <= '0;
          instr_ready <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
`ifdef ALU_CTRL_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      retired_cnt <= '0;
      wb_cnt      <= '0;
    end else if (done) begin
      retired_cnt <= retired_cnt + 16'd1;
      wb_cnt      <= wb_cnt + 16'(wb_q);
    end
`endif
endmodule
